spi_slave_interface: RTL
========================

Name: spi_slave_interface

Overview:
- SPI responder (slave) for the on-board SPI link, the counterpart of our SPI master.
- Runs the same framing: mode 3 (SCLK idles high, data changes on falling edge, sampled on rising edge), 16-bit frames, MSB first, MOSI/MISO idle high.
- Receives a 16-bit word on MOSI and returns a 16-bit word on MISO in the same frame.
- Used as a loopback/peripheral model for board bring-up and as the device-side endpoint in benches.

Parameters:
- FRAME_BITS, 16, bits per frame; sets the width of tx_data and rx_data and the bit-counter limit.
- SYNC_STAGES, 2, flip-flop synchroniser depth on sclk, ss_n and mosi (minimum 2).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from the master; asynchronous to clk.
- ss_n  input  1  active-low slave select; frame delimiter.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- tx_data  input  FRAME_BITS  word returned to the master; captured at frame start.
- rx_data  output  FRAME_BITS  last complete word received; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high while a frame is in progress (state ACTIVE or DONE).
- frame_err  output  1  one-cycle pulse when ss_n deasserts mid-frame.

Behaviour:
- Reset (async assert; deassert synchronised to clk):
  - Outputs: miso=1, rx_data=0, rx_valid=0, busy=0, frame_err=0.
  - Internal: synchroniser flops for sclk, ss_n and mosi preset to 1; bit counter 0; shift registers 0; state IDLE.
- Input handling: sclk, ss_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronised sample with the previous one; each detected edge is a single-cycle event.
  - Constraint: the SCLK half-period must be at least SYNC_STAGES+3 clk cycles. The 98 kHz master gives about 510 cycles.
- States:
  - IDLE: miso=1, busy=0.
    - On a detected ss_n falling edge: load tx_shift <= tx_data, clear rx_shift and the bit count, go to ACTIVE.
    - Level-low ss_n without a detected falling edge (for example, low at reset release) does not start a frame.
  - ACTIVE: busy=1.
    - sclk falling edge: miso <= tx_shift[MSB]; tx_shift shifts left, filling with 0.
    - sclk rising edge: rx_shift <= {rx_shift[FRAME_BITS-2:0], synchronised mosi}; bit count +1.
    - On the FRAME_BITS-th rising edge: rx_data <= the completed word; rx_valid=1 on the following cycle; go to DONE.
    - ss_n rising edge before the count reaches FRAME_BITS: frame_err=1 for one cycle, rx_data unchanged, miso <= 1, go to IDLE.
  - DONE: busy=1; further sclk edges are ignored; miso is held at its last value. On ss_n rising edge: miso <= 1, go to IDLE.
- Simultaneous events:
  - If the FRAME_BITS-th rising edge and the ss_n rising edge are detected in the same cycle, the frame is good: rx_valid=1, no frame_err, go straight to IDLE.
  - If an ss_n falling edge and an sclk edge coincide in IDLE, the sclk edge is ignored.
- tx_data changes after frame start have no effect until the next frame.
- Latency:
  - miso follows a pin-level sclk falling edge by SYNC_STAGES+1 clk cycles.
  - rx_valid follows the pin-level final sclk rising edge by SYNC_STAGES+2 cycles.
- Reset mid-frame: the frame is discarded and all outputs return to reset values immediately. The block waits in IDLE for a fresh ss_n high-to-low transition.
- Counter width is $clog2(FRAME_BITS+1); the count never wraps, because the FSM leaves ACTIVE at FRAME_BITS.

Test Plan:
- Good frame: tx_data=16'hA55A, master sends 16'h1234 at 98 kHz → miso bits on successive falling edges are 1,0,1,0,0,1,0,1,0,1,0,1,1,0,1,0; rx_data=16'h1234; exactly one rx_valid pulse; busy falls after ss_n rises; miso=1 after the frame.
- Back-to-back frames: send 16'hFFFF then 16'h0001 with tx_data changed mid-first-frame from 16'h0F0F to 16'hF0F0 → first frame returns 16'h0F0F and second returns 16'hF0F0; rx_data=16'hFFFF then 16'h0001; two rx_valid pulses.
- Aborted frame: ss_n rises after 9 rising edges → frame_err pulse; no rx_valid; rx_data keeps the previous value; miso=1; next full frame is received correctly.
- Extra clocks: 20 sclk cycles within one ss_n window, sending 16'hBEEF → rx_data=16'hBEEF; edges 17-20 ignored; single rx_valid.
- Coincident end: last rising edge and ss_n rise aligned to the same synchronised cycle → rx_valid=1, frame_err=0.
- Reset mid-frame: assert rst after 5 bits with ss_n held low, then release → outputs at reset values; no frame starts until ss_n toggles high then low; the next frame of 16'hC3C3 is received correctly.

Source files
------------

// File: rtl/spi_slave_interface_if.sv
// SPI slave bus bundle: pin-level SPI signals plus the parallel word side.
// The master modport drives the pins and tx_data; the slave modport is the responder's view.
interface spi_slave_interface_if #(
  parameter int unsigned FRAME_BITS = 16
);
  logic                  sclk;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic [FRAME_BITS-1:0] tx_data;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  frame_err;

  modport master (
    output sclk, ss_n, mosi, tx_data,
    input  miso, rx_data, rx_valid, busy, frame_err
  );

  modport slave (
    input  sclk, ss_n, mosi, tx_data,
    output miso, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_interface.sv
// SPI mode-3 responder: 16-bit MSB-first frames, word returned on MISO in the same frame.
// All SPI pins are synchronised into clk; edges are single-cycle events on the synchronised copies.
module spi_slave_interface #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst,
  spi_slave_interface_if.slave bus
);

  localparam int unsigned CntW  = $clog2(FRAME_BITS + 1);
  localparam int unsigned WarmW = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0]  LastBit  = CntW'(FRAME_BITS - 1);
  // Edge detection needs both the last sync stage and its delayed copy to hold real pin samples.
  localparam logic [WarmW-1:0] WarmDone = WarmW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  logic [1:0]             rst_sync_q;
  logic                   rst_int;
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic [WarmW-1:0]       warm_q;
  logic                   sclk_s, ss_s, mosi_s, edge_en;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_e                 state_q;
  logic                   miso_q, rx_valid_q, busy_q, frame_err_q, valid_pend_q;
  logic [FRAME_BITS-1:0]  rx_data_q, tx_shift_q;
  // MSB of the receive word is never needed from the shifter; the last bit comes from mosi_s.
  logic [FRAME_BITS-2:0]  rx_shift_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [FRAME_BITS-1:0]  rx_word;

  // Reset: asserts asynchronously, releases on clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  // Pin synchronisers (preset high = SPI idle level) and warm-up gate for edge detection.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      sclk_sync_q <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b1;
      ss_prev_q   <= 1'b1;
      warm_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      if (warm_q != WarmDone) warm_q <= warm_q + 1'b1;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  // A low ss_n at reset release is not a falling edge: edges wait for real samples.
  assign edge_en = (warm_q == WarmDone);

  assign sclk_rise = edge_en & ~sclk_prev_q &  sclk_s;
  assign sclk_fall = edge_en &  sclk_prev_q & ~sclk_s;
  assign ss_rise   = edge_en & ~ss_prev_q   &  ss_s;
  assign ss_fall   = edge_en &  ss_prev_q   & ~ss_s;

  assign rx_word = {rx_shift_q, mosi_s};

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= StIdle;
      miso_q       <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      valid_pend_q <= 1'b0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
    end else begin
      // rx_valid trails the rx_data update by one cycle.
      rx_valid_q   <= valid_pend_q;
      valid_pend_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          miso_q <= 1'b1;
          if (ss_fall) begin
            tx_shift_q <= bus.tx_data;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
            state_q    <= StActive;
          end
        end
        StActive: begin
          if (ss_rise) begin
            miso_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
            // Final rising edge coinciding with ss_n release still completes the frame.
            if (sclk_rise && bit_cnt_q == LastBit) begin
              rx_data_q    <= rx_word;
              valid_pend_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            if (sclk_fall) begin
              miso_q     <= tx_shift_q[FRAME_BITS-1];
              tx_shift_q <= {tx_shift_q[FRAME_BITS-2:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift_q <= rx_word[FRAME_BITS-2:0];
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LastBit) begin
                rx_data_q    <= rx_word;
                valid_pend_q <= 1'b1;
                state_q      <= StDone;
              end
            end
          end
        end
        StDone: begin
          if (ss_rise) begin
            miso_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule
